uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter between the two IO write ports (a and b) of the dual-port core.
- Each port has its own byte FIFO, so simultaneous writes from both ports are both kept and neither port's data is lost to the other.
- A round-robin scheduler drains the FIFOs into a one-entry output stage, which drives the UART's valid/ready handshake.
- Sits between the SoC IO decode (UART-data word write strobes) and the UART emitter; its full flags feed IO read-data bit 9 of each port.

---
 rtl/uart_tx_arbiter_pkg.sv | 17 +
 rtl/uart_tx_arbiter_byte_fifo.sv | 66 ++++++
 rtl/uart_tx_arbiter.sv | 127 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the two-port UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam int DROP_W        = 16;
    localparam int DEFAULT_DEPTH = 4;

endpackage

// File: rtl/uart_tx_arbiter_byte_fifo.sv
// 8-bit synchronous FIFO, async active-high reset; pushes while full and pops while empty are ignored.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               wdata,
    input  logic                     pop,
    output logic [7:0]               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        full    = (count_q == (PTR_W+1)'(DEPTH));
        empty   = (count_q == '0);
        count   = count_q;
        rdata   = mem_q[rd_ptr_q];
        do_push = push & ~full;
        do_pop  = pop & ~empty;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter between IO ports a and b, each with its own byte FIFO.
// Define UART_ARB_STATS_EN to add saturating per-port dropped-write counters.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_wr,
    input  logic [7:0]        a_wdata,
    output logic              a_full,
    input  logic              b_wr,
    input  logic [7:0]        b_wdata,
    output logic              b_full,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              idle
`ifdef UART_ARB_STATS_EN
    ,
    output logic [DROP_W-1:0] a_drop_cnt,
    output logic [DROP_W-1:0] b_drop_cnt
`endif
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]     a_rdata, b_rdata;
    logic           a_empty, b_empty;
    logic [PTR_W:0] a_count, b_count;
    logic           a_pop, b_pop;
    logic           load, grant_b;

    state_e         state_q, state_d;
    port_e          rr_q, rr_d;
    logic           tx_valid_q, tx_valid_d;
    logic [7:0]     tx_data_q, tx_data_d;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clk   (clk),
        .reset (reset),
        .push  (a_wr),
        .wdata (a_wdata),
        .pop   (a_pop),
        .rdata (a_rdata),
        .full  (a_full),
        .empty (a_empty),
        .count (a_count)
    );

    byte_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clk   (clk),
        .reset (reset),
        .push  (b_wr),
        .wdata (b_wdata),
        .pop   (b_pop),
        .rdata (b_rdata),
        .full  (b_full),
        .empty (b_empty),
        .count (b_count)
    );

    // With both FIFOs pending the port not granted last wins; rr resets to B so A goes first.
    always_comb begin
        load    = (~tx_valid_q | tx_ready) & (~a_empty | ~b_empty);
        grant_b = ~b_empty & (a_empty | (rr_q == PORT_A));
        a_pop   = load & ~grant_b;
        b_pop   = load & grant_b;

        state_d    = state_q;
        rr_d       = rr_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (load) begin
            state_d    = SEND;
            tx_valid_d = 1'b1;
            tx_data_d  = grant_b ? b_rdata : a_rdata;
            rr_d       = grant_b ? PORT_B : PORT_A;
        end else if (state_q == SEND && tx_ready) begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
        end

        tx_valid = tx_valid_q;
        tx_data  = tx_data_q;
        idle     = (a_count == '0) & (b_count == '0) & ~tx_valid_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_q       <= PORT_B;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

`ifdef UART_ARB_STATS_EN
    logic [DROP_W-1:0] a_drop_q, a_drop_d;
    logic [DROP_W-1:0] b_drop_q, b_drop_d;

    always_comb begin
        a_drop_d = a_drop_q;
        b_drop_d = b_drop_q;
        if (a_wr && a_full && a_drop_q != '1) a_drop_d = a_drop_q + 1'b1;
        if (b_wr && b_full && b_drop_q != '1) b_drop_d = b_drop_q + 1'b1;
        a_drop_cnt = a_drop_q;
        b_drop_cnt = b_drop_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_drop_q <= '0;
            b_drop_q <= '0;
        end else begin
            a_drop_q <= a_drop_d;
            b_drop_q <= b_drop_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-based reference model checked every cycle, plus directed literal checks.
module tb_uart_tx_arbiter;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a_wr = 1'b0, b_wr = 1'b0;
    logic [7:0] a_wdata = '0, b_wdata = '0;
    logic       a_full, b_full, tx_valid, idle;
    logic [7:0] tx_data;
    logic       tx_ready = 1'b1;
`ifdef UART_ARB_STATS_EN
    logic [15:0] a_drop_cnt, b_drop_cnt;
`endif

    uart_tx_arbiter #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .a_wr     (a_wr),
        .a_wdata  (a_wdata),
        .a_full   (a_full),
        .b_wr     (b_wr),
        .b_wdata  (b_wdata),
        .b_full   (b_full),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .idle     (idle)
`ifdef UART_ARB_STATS_EN
        ,
        .a_drop_cnt (a_drop_cnt),
        .b_drop_cnt (b_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: two byte queues, an output register and a last-grant flag.
    logic [7:0] qa[$], qb[$];
    logic       mv;
    logic [7:0] md;
    logic       m_last_b;
    int         mdrop_a, mdrop_b;
    logic       fa, fb, ld;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            qa.delete(); qb.delete();
            mv = 1'b0; md = '0; m_last_b = 1'b1;
            mdrop_a = 0; mdrop_b = 0;
        end else begin
            fa = (qa.size() == DEPTH);
            fb = (qb.size() == DEPTH);
            if (a_wr && fa && mdrop_a < 16'hFFFF) mdrop_a++;
            if (b_wr && fb && mdrop_b < 16'hFFFF) mdrop_b++;
            ld = (!mv || tx_ready) && (qa.size() > 0 || qb.size() > 0);
            if (ld) begin
                if (qa.size() > 0 && (qb.size() == 0 || m_last_b)) begin
                    md = qa.pop_front(); m_last_b = 1'b0;
                end else begin
                    md = qb.pop_front(); m_last_b = 1'b1;
                end
                mv = 1'b1;
            end else if (mv && tx_ready) begin
                mv = 1'b0;
            end
            if (a_wr && !fa) qa.push_back(a_wdata);
            if (b_wr && !fb) qb.push_back(b_wdata);
        end
    end

    // Per-cycle compare, hold-stability check and capture of accepted bytes.
    logic [7:0] obs[$];
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = '0;

    always @(negedge clk) begin
        chk("tx_valid", {31'b0, tx_valid}, {31'b0, mv});
        if (mv) chk("tx_data", {24'b0, tx_data}, {24'b0, md});
        chk("a_full", {31'b0, a_full}, {31'b0, qa.size() == DEPTH});
        chk("b_full", {31'b0, b_full}, {31'b0, qb.size() == DEPTH});
        chk("idle", {31'b0, idle}, {31'b0, (qa.size() == 0 && qb.size() == 0 && !mv)});
`ifdef UART_ARB_STATS_EN
        chk("a_drop_cnt", {16'b0, a_drop_cnt}, mdrop_a);
        chk("b_drop_cnt", {16'b0, b_drop_cnt}, mdrop_b);
`endif
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", {31'b0, tx_valid}, 32'd1);
                chk("hold_data", {24'b0, tx_data}, {24'b0, prev_data});
            end
            prev_hold = tx_valid && !tx_ready;
            prev_data = tx_data;
            if (tx_valid && tx_ready) obs.push_back(tx_data);
        end
    end

    logic [7:0] expq[$];

    task automatic check_stream(input string name);
        chk({name, "_len"}, obs.size(), expq.size());
        for (int i = 0; i < expq.size() && i < obs.size(); i++)
            chk(name, {24'b0, obs[i]}, {24'b0, expq[i]});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a_wr = 1'b0; b_wr = 1'b0;
        step(); step();
        reset = 1'b0;
        obs.delete();
        step();
    endtask

    initial begin
        #1;
        chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
        chk("rst_idle", {31'b0, idle}, 32'd1);
        chk("rst_a_full", {31'b0, a_full}, 32'd0);
        do_reset();

        // Single byte latency
        tx_ready = 1'b1;
        a_wr = 1'b1; a_wdata = 8'h41;
        step();
        a_wr = 1'b0;
        chk("t1_valid_n", {31'b0, tx_valid}, 32'd0);
        step();
        chk("t1_valid_n1", {31'b0, tx_valid}, 32'd1);
        chk("t1_data_n1", {24'b0, tx_data}, 32'h41);
        step();
        chk("t1_valid_n2", {31'b0, tx_valid}, 32'd0);
        chk("t1_idle", {31'b0, idle}, 32'd1);
        expq = '{8'h41};
        check_stream("t1_stream");

        // Simultaneous writes
        do_reset();
        a_wr = 1'b1; a_wdata = 8'h41; b_wr = 1'b1; b_wdata = 8'h42;
        step();
        a_wr = 1'b0; b_wr = 1'b0;
        repeat (5) step();
        expq = '{8'h41, 8'h42};
        check_stream("t2_stream");

        // Parallel bursts alternate
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a_wr = 1'b1; a_wdata = 8'h30 + 8'(i);
            b_wr = 1'b1; b_wdata = 8'h60 + 8'(i);
            step();
        end
        a_wr = 1'b0; b_wr = 1'b0;
        repeat (10) step();
        expq = '{8'h30, 8'h60, 8'h31, 8'h61, 8'h32, 8'h62, 8'h33, 8'h63};
        check_stream("t3_stream");

        // Fill while stalled, drop on full
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a_wr = 1'b1; a_wdata = 8'h10 + 8'(i);
            step();
            if (i == 3) chk("t4_not_full", {31'b0, a_full}, 32'd0);
            if (i == 4) chk("t4_full", {31'b0, a_full}, 32'd1);
        end
        a_wr = 1'b0;
        chk("t4_hold_data", {24'b0, tx_data}, 32'h10);
`ifdef UART_ARB_STATS_EN
        chk("t4_drop", {16'b0, a_drop_cnt}, 32'd1);
`endif
        step();
        tx_ready = 1'b1;
        repeat (8) step();
        expq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        check_stream("t4_stream");

        // Toggling ready
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i < 4) begin a_wr = 1'b1; a_wdata = 8'h50 + 8'(i); end
            else a_wr = 1'b0;
            tx_ready = ~tx_ready;
            step();
        end
        a_wr = 1'b0;
        tx_ready = 1'b1;
        repeat (3) step();
        expq = '{8'h50, 8'h51, 8'h52, 8'h53};
        check_stream("t5_stream");

        // Asynchronous reset mid-transfer
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_wr = 1'b1; a_wdata = 8'h70 + 8'(i);
            step();
        end
        a_wr = 1'b0;
        chk("t6_pre_valid", {31'b0, tx_valid}, 32'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_valid", {31'b0, tx_valid}, 32'd0);
        chk("t6_async_full", {31'b0, a_full}, 32'd0);
        chk("t6_async_idle", {31'b0, idle}, 32'd1);
        obs.delete();
        step(); step();
        reset = 1'b0;
        tx_ready = 1'b1;
        repeat (8) step();
        expq.delete();
        check_stream("t6_stream");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
